// File: rtl/flt_pds2_selftest_top_if.sv
// rtl/flt_pds2_selftest_top_if.sv - result stream interface for the flt_pds2 self-test wrapper
interface flt_pds2_selftest_top_if;
  logic [31:0] tdata;
  logic        tvalid;

  modport master (output tdata, output tvalid);
  modport slave  (input  tdata, input  tvalid);
endinterface

// File: rtl/flt_pds2_selftest_top.sv
// rtl/flt_pds2_selftest_top.sv - int32 to fp32 converter self-test: stimulus, 3-stage pipeline, checker
module flt_pds2_selftest_top #(
  parameter int          TEST_NUM  = 1000,
  parameter logic [31:0] LFSR_SEED = 32'hACE12468
) (
  input  logic                            i_aclk,
  input  logic                            i_areset,
  output logic                            o_success,
  flt_pds2_selftest_top_if.master         o_axi4s_result
);

  localparam logic [31:0] TEST_NUM_W = 32'(TEST_NUM);
  localparam logic [31:0] LFSR_MASK  = 32'h80200003;

  // Independent reference conversion: priority scan for the leading one, then
  // explicit shift left/right into a 23-bit mantissa with guard/sticky extraction.
  function automatic logic [31:0] ref_cvt(input logic [31:0] x);
    logic        sgn;
    logic [31:0] m;
    logic [31:0] t;
    logic [31:0] low_mask;
    logic [4:0]  p;
    logic [4:0]  sh;
    logic [22:0] man;
    logic [23:0] man_r;
    logic        g;
    logic        st;
    logic        up;
    logic [7:0]  e;
    sgn = x[31];
    m   = sgn ? (~x + 32'd1) : x;
    p   = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (m[i]) p = 5'(i);
    end
    g  = 1'b0;
    st = 1'b0;
    if (p <= 5'd23) begin
      sh  = 5'd23 - p;
      t   = m << sh;
      man = t[22:0];
    end else begin
      sh       = p - 5'd23;
      t        = m >> sh;
      man      = t[22:0];
      t        = m >> (sh - 5'd1);
      g        = t[0];
      low_mask = (32'd1 << (sh - 5'd1)) - 32'd1;
      st       = |(m & low_mask);
    end
    up    = g & (st | man[0]);
    man_r = {1'b0, man} + {23'd0, up};
    e     = 8'd127 + {3'd0, p} + {7'd0, man_r[23]};
    if (m == 32'd0) ref_cvt = 32'd0;
    else            ref_cvt = {sgn, e, man_r[22:0]};
  endfunction

  // ---------------------------------------------------------------- stimulus
  logic [31:0] vec_cnt_q, vec_cnt_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic        issue;
  logic [31:0] vec;

  // Select directed or LFSR vector and advance the counter / LFSR.
  always_comb begin
    issue     = (vec_cnt_q < TEST_NUM_W);
    vec       = lfsr_q;
    vec_cnt_d = vec_cnt_q;
    lfsr_d    = lfsr_q;
    case (vec_cnt_q)
      32'd0:   vec = 32'h00000000;
      32'd1:   vec = 32'h00000001;
      32'd2:   vec = 32'hFFFFFFFF;
      32'd3:   vec = 32'h00000003;
      32'd4:   vec = 32'h7FFFFFFF;
      32'd5:   vec = 32'h80000000;
      32'd6:   vec = 32'h01000001;
      32'd7:   vec = 32'h01000003;
      default: vec = lfsr_q;
    endcase
    if (issue) begin
      vec_cnt_d = vec_cnt_q + 32'd1;
      if (vec_cnt_q >= 32'd8) begin
        lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'd0);
      end
    end
  end

  // Stimulus state registers.
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      vec_cnt_q <= 32'd0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      vec_cnt_q <= vec_cnt_d;
      lfsr_q    <= lfsr_d;
    end
  end

  // ---------------------------------------------------------------- pipeline
  logic        s1_vld_q, s1_sign_q;
  logic [31:0] s1_mag_q, s1_ref_q;
  logic        s2_vld_q, s2_sign_q, s2_zero_q;
  logic [4:0]  s2_p_q;
  logic [31:0] s2_norm_q, s2_ref_q;
  logic        s3_vld_q;
  logic [31:0] s3_res_q, s3_ref_q;

  logic [4:0]  lod_p;
  logic [31:0] lod_norm;
  logic [22:0] rnd_man;
  logic        rnd_up;
  logic [23:0] rnd_sum;
  logic [7:0]  rnd_exp;
  logic [31:0] rnd_res;

  // Stage 2 leading-one detect and normalise; stage 3 round-to-nearest-even.
  always_comb begin
    lod_p = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (s1_mag_q[i]) lod_p = 5'(i);
    end
    lod_norm = s1_mag_q << (5'd31 - lod_p);
    rnd_man  = s2_norm_q[30:8];
    rnd_up   = s2_norm_q[7] & ((|s2_norm_q[6:0]) | s2_norm_q[8]);
    rnd_sum  = {1'b0, rnd_man} + {23'd0, rnd_up};
    rnd_exp  = 8'd127 + {3'd0, s2_p_q} + {7'd0, rnd_sum[23]};
    rnd_res  = s2_zero_q ? 32'd0 : {s2_sign_q, rnd_exp, rnd_sum[22:0]};
  end

  // Pipeline registers; the reference result travels alongside the data.
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      s1_vld_q  <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_mag_q  <= 32'd0;
      s1_ref_q  <= 32'd0;
      s2_vld_q  <= 1'b0;
      s2_sign_q <= 1'b0;
      s2_zero_q <= 1'b1;
      s2_p_q    <= 5'd0;
      s2_norm_q <= 32'd0;
      s2_ref_q  <= 32'd0;
      s3_vld_q  <= 1'b0;
      s3_res_q  <= 32'd0;
      s3_ref_q  <= 32'd0;
    end else begin
      s1_vld_q <= issue;
      s2_vld_q <= s1_vld_q;
      s3_vld_q <= s2_vld_q;
      if (issue) begin
        s1_sign_q <= vec[31];
        s1_mag_q  <= vec[31] ? (~vec + 32'd1) : vec;
        s1_ref_q  <= ref_cvt(vec);
      end
      if (s1_vld_q) begin
        s2_sign_q <= s1_sign_q;
        s2_zero_q <= (s1_mag_q == 32'd0);
        s2_p_q    <= lod_p;
        s2_norm_q <= lod_norm;
        s2_ref_q  <= s1_ref_q;
      end
      // Output holds the last result once the run is over.
      if (s2_vld_q) begin
        s3_res_q <= rnd_res;
        s3_ref_q <= s2_ref_q;
      end
    end
  end

  assign o_axi4s_result.tdata  = s3_res_q;
  assign o_axi4s_result.tvalid = s3_vld_q;

  // ---------------------------------------------------------------- checker
  logic [31:0] cmp_cnt_q;
  logic        error_q, done_q, success_q;
  logic        mism, last_cmp;

  // Compare observed output against the delayed reference.
  always_comb begin
    mism     = o_axi4s_result.tvalid && (o_axi4s_result.tdata != s3_ref_q);
    last_cmp = o_axi4s_result.tvalid && (cmp_cnt_q == TEST_NUM_W - 32'd1);
  end

  // Sticky error/done flags and registered success.
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      cmp_cnt_q <= 32'd0;
      error_q   <= 1'b0;
      done_q    <= 1'b0;
      success_q <= 1'b0;
    end else begin
      if (o_axi4s_result.tvalid) cmp_cnt_q <= cmp_cnt_q + 32'd1;
      error_q   <= error_q | mism;
      done_q    <= done_q | last_cmp;
      success_q <= (done_q | last_cmp) & ~(error_q | mism);
    end
  end

  assign o_success = success_q;

endmodule

// File: tb/tb_flt_pds2_selftest_top.sv
// tb/tb_flt_pds2_selftest_top.sv - self-checking bench for flt_pds2_selftest_top
module tb_flt_pds2_selftest_top;
  localparam int N = 1000;

  logic clk = 1'b0;
  logic areset;
  logic success;
  flt_pds2_selftest_top_if res_if ();

  flt_pds2_selftest_top #(.TEST_NUM(N), .LFSR_SEED(32'hACE12468)) dut (
    .i_aclk         (clk),
    .i_areset       (areset),
    .o_success      (success),
    .o_axi4s_result (res_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
  } vec_t;

  vec_t        dir_tab [8];
  logic [31:0] vecs  [N];
  logic [31:0] model [N];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] bad_val;

  // Convert via an exact double, then round the 52-bit fraction to 23 bits.
  function automatic logic [31:0] model_cvt(input logic [31:0] x);
    real         r;
    logic [63:0] b;
    logic [51:0] fr;
    logic [23:0] man;
    logic        up;
    int          e;
    logic [7:0]  e8;
    if (x == 32'd0) return 32'd0;
    r   = $itor($signed(x));
    b   = $realtobits(r);
    fr  = b[51:0];
    e   = int'(b[62:52]) - 1023 + 127;
    up  = fr[28] & ((|fr[27:0]) | fr[29]);
    man = {1'b0, fr[51:29]} + {23'd0, up};
    if (man[23]) e = e + 1;
    e8 = 8'(e);
    return {b[63], e8, man[22:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Cycle c is sampled on the falling edge; cycle 0 is the one where reset drops.
  task automatic run_cycles(input int max_c, input bit check_data, input bit inject);
    bit exp_v;
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clk);
      if (inject && c == 504) release res_if.tdata;
      exp_v = (c >= 3) && (c < 3 + N);
      check($sformatf("tvalid c%0d", c), {31'd0, res_if.tvalid}, {31'd0, exp_v});
      check($sformatf("success c%0d", c), {31'd0, success},
            {31'd0, (!inject && c >= 3 + N)});
      if (check_data) begin
        if (c < 3) check($sformatf("tdata idle c%0d", c), res_if.tdata, 32'd0);
        else if (exp_v) begin
          check($sformatf("tdata v%0d", c - 3), res_if.tdata, model[c-3]);
          if (c - 3 < 8)
            check($sformatf("directed %0d", c - 3), res_if.tdata, dir_tab[c-3].dout);
        end else check($sformatf("tdata hold c%0d", c), res_if.tdata, model[N-1]);
      end
      if (inject && c == 503) begin
        bad_val = model[500] ^ 32'h0000_0100;
        force res_if.tdata = bad_val;
      end
    end
  endtask

  task automatic reset_cycles(input int n);
    areset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst success", {31'd0, success}, 32'd0);
      check("rst tvalid", {31'd0, res_if.tvalid}, 32'd0);
      check("rst tdata", res_if.tdata, 32'd0);
    end
    areset = 1'b0;
  endtask

  initial begin
    logic [31:0] s;
    dir_tab[0] = '{32'h00000000, 32'h00000000};
    dir_tab[1] = '{32'h00000001, 32'h3F800000};
    dir_tab[2] = '{32'hFFFFFFFF, 32'hBF800000};
    dir_tab[3] = '{32'h00000003, 32'h40400000};
    dir_tab[4] = '{32'h7FFFFFFF, 32'h4F000000};
    dir_tab[5] = '{32'h80000000, 32'hCF000000};
    dir_tab[6] = '{32'h01000001, 32'h4B800000};
    dir_tab[7] = '{32'h01000003, 32'h4B800002};
    s = 32'hACE12468;
    for (int k = 0; k < N; k++) begin
      if (k < 8) vecs[k] = dir_tab[k].din;
      else begin
        vecs[k] = s;
        s = (s >> 1) ^ (s[0] ? 32'h80200003 : 32'd0);
      end
      model[k] = model_cvt(vecs[k]);
    end
    // Model sanity on random integers against the directed table style cases.
    for (int k = 0; k < 8; k++)
      check($sformatf("model dir %0d", k), model_cvt(dir_tab[k].din), dir_tab[k].dout);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] p2;
      p2 = 32'd1 << $urandom_range(0, 30);
      check("model pow2", model_cvt(p2), {1'b0, 8'(127 + $clog2(p2)), 23'd0});
    end

    areset = 1'b1;
    bad_val = 32'd0;
    repeat (2) @(posedge clk);

    // Full clean run.
    reset_cycles(3);
    run_cycles(N + 10, 1'b1, 1'b0);

    // Mid-run reset at cycle 400, then a full clean run afterwards.
    reset_cycles(1);
    run_cycles(399, 1'b1, 1'b0);
    reset_cycles(1);
    run_cycles(N + 10, 1'b1, 1'b0);

    // Corrupted result on vector 500 must keep success low.
    reset_cycles(1);
    run_cycles(N + 10, 1'b0, 1'b1);
    check("inject final success", {31'd0, success}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
